// File: rtl/step_pkg.sv
// Shared types and constants for the step pulse generator.
// STEP_GEN_JITTER_EN adds the gait-jitter LFSR constants and step function.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } step_state_t;

    localparam int RATE_W          = 3;
    localparam int TICK_CNT_W      = 10;
    localparam int DEF_PULSE_TICKS = 3;

    // Period in 600 Hz ticks for 32,22,16,12,8,4,2,1 steps/s
    localparam logic [TICK_CNT_W-1:0] RATE_PERIOD [0:7] = '{
        10'd19, 10'd27, 10'd38, 10'd50, 10'd75, 10'd150, 10'd300, 10'd600
    };

`ifdef STEP_GEN_JITTER_EN
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAP_MASK), cur[15:1]};
    endfunction
`endif

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// clr restarts the count so the first tick lands TICK_DIV cycles later.
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/step_pulse_gen.sv
// Step pulse generator: counted or continuous pulse trains at 8 cadences.
// Optional STEP_GEN_JITTER_EN stretches each LOW phase by 0..3 LFSR-chosen ticks.
//
// state | meaning
// IDLE  | waiting for start
// HIGH  | step_out asserted for PULSE_TICKS ticks
// LOW   | step_out low for the rest of the period
// DONE  | one-cycle done strobe after a counted run
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 600,
    parameter int PULSE_TICKS = DEF_PULSE_TICKS,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate_sel,
    input  logic [CNT_W-1:0]  step_count,
    output logic              step_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  steps_sent
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam logic [TICK_CNT_W-1:0] HIGH_LOAD = TICK_CNT_W'(PULSE_TICKS - 1);
    // Down-counter load for LOW is period - PULSE_TICKS - 1 (terminal count is zero)
    localparam logic [TICK_CNT_W-1:0] LOW_BASE  = TICK_CNT_W'(PULSE_TICKS + 1);

    step_state_t             state;
    step_state_t             state_nxt;
    logic [TICK_CNT_W-1:0]   period_lat;
    logic [CNT_W-1:0]        count_lat;
    logic [TICK_CNT_W-1:0]   tick_cnt;
    logic [TICK_CNT_W-1:0]   jitter;
    logic                    tick;
    logic                    tc;
    logic                    accept;
    logic                    enter_high;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    assign tc         = tick && (tick_cnt == '0);
    assign accept     = (state == IDLE) && start && !stop;
    assign enter_high = (state_nxt == HIGH) && (state != HIGH);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !stop) state_nxt = HIGH;
            end
            HIGH: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tc) begin
                    if ((count_lat != '0) && (steps_sent == count_lat)) state_nxt = DONE;
                    else                                                  state_nxt = LOW;
                end
            end
            LOW: begin
                if (stop)    state_nxt = IDLE;
                else if (tc) state_nxt = HIGH;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef STEP_GEN_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (enter_high) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign jitter = {{(TICK_CNT_W-2){1'b0}}, lfsr[1:0]};
`else
    assign jitter = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            period_lat <= '0;
            count_lat  <= '0;
            tick_cnt   <= '0;
            steps_sent <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                period_lat <= RATE_PERIOD[rate_sel];
                count_lat  <= step_count;
                steps_sent <= CNT_W'(1);
                tick_cnt   <= HIGH_LOAD;
            end else if (state == LOW && state_nxt == HIGH) begin
                steps_sent <= steps_sent + CNT_W'(1);
                tick_cnt   <= HIGH_LOAD;
            end else if (state == HIGH && state_nxt == LOW) begin
                tick_cnt <= period_lat - LOW_BASE + jitter;
            end else if (busy && tick && (tick_cnt != '0)) begin
                tick_cnt <= tick_cnt - TICK_CNT_W'(1);
            end
        end
    end

    assign step_out = (state == HIGH);
    assign busy     = (state == HIGH) || (state == LOW);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen with TICK_DIV = 10.
// Build with STEP_GEN_JITTER_EN defined to exercise the jitter model as well.
module tb_step_pulse_gen;

`ifdef STEP_GEN_JITTER_EN
    localparam bit JIT = 1'b1;
`else
    localparam bit JIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [2:0]  rate_sel = 3'd0;
    logic [15:0] step_count = 16'd0;
    logic        step_out;
    logic        busy;
    logic        done;
    logic [15:0] steps_sent;

    step_pulse_gen #(
        .CLK_HZ  (6000),
        .TICK_HZ (600)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .rate_sel   (rate_sel),
        .step_count (step_count),
        .step_out   (step_out),
        .busy       (busy),
        .done       (done),
        .steps_sent (steps_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int rise_q[$];
    int fall_q[$];
    int sent_q[$];
    int done_q[$];
    int done_busy_q[$];
    logic prev_out = 1'b0;

    always @(negedge clk) begin
        if (step_out === 1'b1 && prev_out === 1'b0) begin
            rise_q.push_back(cyc);
            sent_q.push_back(int'(steps_sent));
        end
        if (step_out === 1'b0 && prev_out === 1'b1) fall_q.push_back(cyc);
        if (done === 1'b1) begin
            done_q.push_back(cyc);
            done_busy_q.push_back(int'(busy));
        end
        prev_out = step_out;
    end

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_ref(input logic [15:0] l);
        int unsigned v;
        int unsigned b;
        v = l;
        b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (b << 15));
    endfunction

    const int PERIOD_TBL [0:7] = '{19, 27, 38, 50, 75, 150, 300, 600};

    typedef struct {
        logic [2:0] rate;
        int         cnt;
        int         period;
        bit         perturb;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        rise_q.delete();
        fall_q.delete();
        sent_q.delete();
        done_q.delete();
        done_busy_q.delete();
    endtask

    task automatic do_start(input logic [2:0] rate, input int cnt, output int sc);
        clear_q();
        rate_sel   = rate;
        step_count = 16'(cnt);
        start      = 1'b1;
        sc         = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit perturb);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < budget) begin
            if (perturb && n == 60) begin
                rate_sel   = 3'($urandom);
                step_count = 16'($urandom);
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            step(1);
            n++;
        end
        start = 1'b0;
        step(2);
        chk({tag, " done strobes"}, done_q.size(), 1);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle step_out"}, int'(step_out), 0);
    endtask

    task automatic check_pulses(input string tag, input int n_exp, input int period,
                                input int sc, input bit counted);
        int jit;
        chk({tag, " rises"}, rise_q.size(), n_exp);
        if (rise_q.size() > 0) chk({tag, " first rise"}, rise_q[0], sc + 1);
        for (int k = 0; k < rise_q.size(); k++) begin
            m_lfsr = lfsr_ref(m_lfsr);
            jit    = JIT ? int'(m_lfsr[1:0]) : 0;
            chk({tag, " steps_sent at rise"}, sent_q[k], k + 1);
            if (k + 1 < rise_q.size()) begin
                chk({tag, " spacing"}, rise_q[k+1] - rise_q[k], (period + jit) * 10);
                if (k < fall_q.size()) chk({tag, " high width"}, fall_q[k] - rise_q[k], 30);
            end
        end
        if (counted) begin
            if (done_q.size() > 0 && rise_q.size() > 0) begin
                chk({tag, " done cycle"}, done_q[0], rise_q[rise_q.size()-1] + 30);
                chk({tag, " busy at done"}, done_busy_q[0], 0);
            end
            chk({tag, " final steps_sent"}, int'(steps_sent), n_exp);
        end else begin
            chk({tag, " no done"}, done_q.size(), 0);
        end
    endtask

    initial begin
        int sc;
        int n;
        int sp;
        logic [2:0] r;
        int c;

        tbl[0] = '{3'd0, 3, 19, 1'b0};
        tbl[1] = '{3'd0, 3, 19, 1'b1};
        tbl[2] = '{3'd5, 2, 150, 1'b0};
        tbl[3] = '{3'd6, 1, 300, 1'b0};
        tbl[4] = '{3'd3, 4, 50, 1'b1};
        tbl[5] = '{3'd1, 2, 27, 1'b0};
        tbl[6] = '{3'd2, 2, 38, 1'b1};
        tbl[7] = '{3'd4, 1, 75, 1'b0};
        tbl[8] = '{3'd7, 2, 600, 1'b0};

        step(3);
        chk("reset step_out", int'(step_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset steps_sent", int'(steps_sent), 0);
        rst = 1'b0;
        m_lfsr = 16'hACE1;

        // Reset in the middle of the second pulse
        do_start(3'd0, 0, sc);
        step(200);
        chk("pre-rst busy", int'(busy), 1);
        chk("pre-rst steps_sent", int'(steps_sent), 2);
        rst = 1'b1;
        step(1);
        chk("mid-rst step_out", int'(step_out), 0);
        chk("mid-rst busy", int'(busy), 0);
        chk("mid-rst done", int'(done), 0);
        chk("mid-rst steps_sent", int'(steps_sent), 0);
        step(2);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        clear_q();
        step(40);
        chk("post-rst no rise", rise_q.size(), 0);

        // Table-driven counted runs; perturbed rows change inputs and re-pulse start mid-run
        for (int i = 0; i < 9; i++) begin
            do_start(tbl[i].rate, tbl[i].cnt, sc);
            wait_done($sformatf("tbl%0d", i), tbl[i].cnt * (tbl[i].period + 6) * 10 + 50,
                      tbl[i].perturb);
            check_pulses($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].period, sc, 1'b1);
        end

        // start and stop together in IDLE: stop wins
        clear_q();
        rate_sel = 3'd0;
        step_count = 16'd2;
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        chk("start+stop busy", int'(busy), 0);
        chk("start+stop step_out", int'(step_out), 0);
        step(40);
        chk("start+stop no rise", rise_q.size(), 0);

        // Continuous run at 1 step/s, stopped during the fifth pulse
        do_start(3'd7, 0, sc);
        n = 0;
        while (rise_q.size() < 5 && n < 5 * 6100) begin
            step(1);
            n++;
        end
        step(5);
        chk("cont high before stop", int'(step_out), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop step_out", int'(step_out), 0);
        chk("stop busy", int'(busy), 0);
        chk("stop done", int'(done), 0);
        chk("stop steps_sent", int'(steps_sent), 5);
        step(20);
        chk("stop steps_sent held", int'(steps_sent), 5);
        check_pulses("cont", 5, 600, sc, 1'b0);

        // Randomized counted runs against the reference
        for (int i = 0; i < 4; i++) begin
            r = 3'($urandom_range(0, 4));
            c = $urandom_range(1, 4);
            do_start(r, c, sc);
            wait_done($sformatf("rnd%0d", i), c * (PERIOD_TBL[r] + 6) * 10 + 50,
                      1'($urandom_range(0, 1)));
            check_pulses($sformatf("rnd%0d", i), c, PERIOD_TBL[r], sc, 1'b1);
        end

        // 100 pulses at the fastest rate: spacing bounded and matching the jitter model
        do_start(3'd0, 100, sc);
        wait_done("long", 100 * 25 * 10 + 50, 1'b0);
        for (int k = 0; k + 1 < rise_q.size(); k++) begin
            sp = rise_q[k+1] - rise_q[k];
            chk("long spacing in range", int'(sp >= 190 && sp <= 220), 1);
        end
        check_pulses("long", 100, 19, sc, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
